request_queue: RTL and testbench

- Front-end stage directly upstream of the LED walker; drives the walker's request input from a raw push-button.
- Synchronises and debounces the button, counts presses into a saturating pending queue, and presents one request per queued press.
- A request is presented only while the walker is idle. It is held until the walker shows busy, so the walker's slow 1 Hz sampling never loses a press.

---
 rtl/request_queue.sv | 155 +++++++++++++++
 tb/tb_request_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_queue.sv
// Push-button front end for the LED walker: synchronises and debounces the button, counts
// presses into a saturating queue and hands them to the walker one request at a time.
module request_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 120_000,
    parameter int unsigned PW              = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_btn,
    input  logic          i_busy,
    input  logic          i_clr_ovf,
    output logic          o_request,
    output logic [PW-1:0] o_pending,
    output logic          o_overflow
);

    localparam int unsigned DbCycles = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int unsigned CntW     = (DbCycles > 1) ? $clog2(DbCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DbCycles - 1);
    localparam logic [PW-1:0]   PendMax = {PW{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitDone
    } state_e;

    logic            btn_meta_q, btn_sync_q;
    logic            db_level_q, db_level_d;
    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic            press;
    logic            accept;
    logic [PW-1:0]   pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic            ovf_set;
    state_e          state_q, state_d;
    logic            request_q, request_d;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= i_btn;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Count consecutive cycles the synced level disagrees; adopt it after DbCycles of them.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press      = 1'b0;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == CntLast) begin
                db_level_d = btn_sync_q;
                press      = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign accept = (state_q == StReq) && i_busy;

    // A press and an accept in the same cycle cancel, so saturation cannot flag overflow then.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        case ({press, accept})
            2'b10: begin
                if (pend_q == PendMax) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end
            2'b01: begin
                if (pend_q != '0) begin
                    pend_d = pend_q - 1'b1;
                end
            end
            default: ;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= StIdle;
            request_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            request_q <= request_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if ((pend_q != '0) && !i_busy) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (i_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!i_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered alongside the state so o_request is high exactly while in StReq.
    always_comb begin
        request_d = (state_d == StReq);
    end

    assign o_request  = request_q;
    assign o_pending  = pend_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_request_queue.sv
// Bench for request_queue: directed scenarios plus random button/busy traffic, checked every
// cycle against a behavioural model of press counting and the request handshake.
module tb_request_queue;

    localparam int DB   = 4;
    localparam int PW   = 2;
    localparam int MAXP = (1 << PW) - 1;
    localparam int PhIdle = 0;
    localparam int PhReq  = 1;
    localparam int PhWait = 2;

    logic          clk;
    logic          rst_n;
    logic          btn;
    logic          busy;
    logic          clr;
    logic          o_request;
    logic [PW-1:0] o_pending;
    logic          o_overflow;

    logic walk_en;
    logic walk_busy;
    logic force_busy;
    int   walk_delay;
    int   walk_hold;
    int   wcnt;
    int   whold;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: synchroniser samples, debounced level, disagreeing-run length, queue.
    bit m_valid = 0;
    bit m_s1, m_s2, m_level;
    int m_run;
    int m_pend;
    bit m_ovf;
    int m_phase;
    bit m_press, m_accept, m_ovf_set;

    assign busy = walk_en ? walk_busy : force_busy;

    request_queue #(
        .DEBOUNCE_CYCLES(DB),
        .PW             (PW)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_btn     (btn),
        .i_busy    (busy),
        .i_clr_ovf (clr),
        .o_request (o_request),
        .o_pending (o_pending),
        .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
            m_pend = 0; m_ovf = 0; m_phase = PhIdle; m_valid = 1;
        end else begin
            m_press  = 0;
            m_accept = (m_phase == PhReq) && busy;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = m_s2;
                    m_press = m_level;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
            case (m_phase)
                PhIdle:  if (m_pend != 0 && !busy) m_phase = PhReq;
                PhReq:   if (busy) m_phase = PhWait;
                default: if (!busy) m_phase = PhIdle;
            endcase
            m_ovf_set = 0;
            if (m_press && !m_accept) begin
                if (m_pend == MAXP) m_ovf_set = 1;
                else m_pend = m_pend + 1;
            end else if (m_accept && !m_press && m_pend > 0) begin
                m_pend = m_pend - 1;
            end
            if (m_ovf_set) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("request", int'(o_request), int'(m_phase == PhReq));
            check("pending", int'(o_pending), m_pend);
            check("overflow", int'(o_overflow), int'(m_ovf));
        end
    end

    // Walker stand-in: raises busy walk_delay cycles into a request, holds it a few cycles.
    initial forever begin
        @(negedge clk);
        if (!walk_en || !rst_n) begin
            walk_busy = 0;
            wcnt      = 0;
        end else if (walk_busy) begin
            if (whold <= 1) walk_busy = 0;
            else whold--;
        end else if (o_request) begin
            wcnt++;
            if (wcnt >= walk_delay) begin
                walk_busy = 1;
                wcnt      = 0;
                whold     = $urandom_range(1, walk_hold);
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic press();
        btn = 1;
        repeat (8) @(negedge clk);
        btn = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_pending(input string nm, input int val, input int limit);
        int i = 0;
        while (int'(o_pending) != val && i < limit) begin
            @(negedge clk);
            i++;
        end
        check(nm, int'(o_pending), val);
    endtask

    task automatic wait_req(input string nm, input int limit);
        int i = 0;
        while (!o_request && i < limit) begin
            @(negedge clk);
            i++;
        end
        check(nm, int'(o_request), 1);
    endtask

    initial begin
        int bhold;
        rst_n = 0; btn = 1; clr = 0; force_busy = 0;
        walk_en = 1; walk_busy = 0; walk_delay = 10; walk_hold = 4; wcnt = 0; whold = 0;

        // Reset with the button held, then debounce it into one press.
        repeat (3) @(negedge clk);
        check("rst_request", int'(o_request), 0);
        check("rst_pending", int'(o_pending), 0);
        check("rst_overflow", int'(o_overflow), 0);
        rst_n = 1;
        repeat (5) @(negedge clk);
        check("pend_before_debounce", int'(o_pending), 0);
        @(negedge clk);
        check("pend_after_debounce", int'(o_pending), 1);
        check("req_not_yet", int'(o_request), 0);
        @(negedge clk);
        check("req_rise", int'(o_request), 1);
        repeat (9) @(negedge clk);
        check("req_held_10", int'(o_request), 1);
        @(negedge clk);
        check("req_drop", int'(o_request), 0);
        check("pend_accepted", int'(o_pending), 0);
        btn = 0;
        repeat (20) @(negedge clk);
        check("release_no_event", int'(o_pending), 0);

        // Short glitch must not register.
        btn = 1;
        repeat (3) @(negedge clk);
        btn = 0;
        repeat (12) @(negedge clk);
        check("glitch_pending", int'(o_pending), 0);
        check("glitch_request", int'(o_request), 0);

        // Queue while busy, saturate, clear overflow, then drain.
        walk_en = 0; force_busy = 1;
        repeat (3) press();
        check("queued_3", int'(o_pending), 3);
        check("queued_no_req", int'(o_request), 0);
        press();
        check("sat_pending", int'(o_pending), 3);
        check("sat_overflow", int'(o_overflow), 1);
        clr = 1;
        @(negedge clk);
        clr = 0;
        check("clr_overflow", int'(o_overflow), 0);
        check("clr_keeps_pending", int'(o_pending), 3);
        walk_delay = 3;
        walk_en = 1;
        wait_pending("drained", 0, 300);

        // Press event lands on the accept cycle.
        walk_en = 0; force_busy = 1;
        repeat (20) @(negedge clk);
        press();
        press();
        check("pend_two", int'(o_pending), 2);
        force_busy = 0;
        wait_req("req_for_coincide", 10);
        btn = 1;
        repeat (5) @(negedge clk);
        force_busy = 1;
        @(negedge clk);
        check("coincide_pending", int'(o_pending), 2);
        check("coincide_req_drop", int'(o_request), 0);
        btn = 0;
        repeat (10) @(negedge clk);
        force_busy = 0;
        wait_req("req_before_reset", 10);
        rst_n = 0;
        @(negedge clk);
        check("reset_in_req_request", int'(o_request), 0);
        check("reset_in_req_pending", int'(o_pending), 0);
        rst_n = 1;

        // Random traffic against the model.
        walk_en = 1; walk_delay = 2; walk_hold = 5; bhold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (bhold == 0) begin
                btn   = ~btn;
                bhold = $urandom_range(1, 12);
            end else begin
                bhold--;
            end
            clr   = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            if (c % 400 == 0) begin
                walk_en    = ($urandom_range(0, 3) != 0);
                force_busy = $urandom_range(0, 1) != 0;
                walk_delay = $urandom_range(0, 12);
            end
        end
        rst_n = 1; clr = 0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
